// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and the default operand width.
// Build option: SERIAL_SUB_OVF_EN adds a signed-overflow result flag.
package serial_sub_pkg;

   // Controller states; encodings are fixed so waveforms stay readable.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Default operand/result width.
   localparam int DEFAULT_WIDTH = 4;

   // Width of a counter that can hold the values 0..w.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master = producer of operands and consumer of results; slave = the subtractor.
// Build option: SERIAL_SUB_OVF_EN adds the ovf result bit.
interface serial_subtractor_if
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   // Operand channel
   logic             in_valid;
   logic             in_ready;
   logic             bin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   // Result channel
   logic             out_valid;
   logic             out_ready;
   logic             bout;
   logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, bin, a, b, out_ready,
      input  in_ready, out_valid, bout, diff
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, bin, a, b, out_ready,
      output in_ready, out_valid, bout, diff
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - z, bo = borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ z;
   assign bo = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {bout, diff} = a - b - bin, LSB first, one bit per clock.
// Latency: result valid WIDTH edges after the operand accept edge; one op per WIDTH+2 cycles at best.
// Backpressure: operands taken only in IDLE; result and flags held in DONE until out_ready.
// Build option: SERIAL_SUB_OVF_EN adds bus.ovf, the signed two's-complement overflow flag.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   serial_subtractor_if.slave bus
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q,  state_d;
   logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
   logic               borrow_q, borrow_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   diff_q,   diff_d;
   logic               bout_q,   bout_d;
`ifdef SERIAL_SUB_OVF_EN
   logic               a_msb_q,  a_msb_d;
   logic               b_msb_q,  b_msb_d;
   logic               ovf_q,    ovf_d;
`endif

   logic               fs_d;
   logic               fs_bo;

   // The single subtractor cell, reused on every SHIFT cycle.
   full_subtractor u_fs (
      .x  (a_sh_q[0]),
      .y  (b_sh_q[0]),
      .z  (borrow_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   // Next-state and datapath: load in IDLE, one bit per edge in SHIFT, hold in DONE.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               borrow_d = bus.bin;
               cnt_d    = '0;
               state_d  = SHIFT;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d  = bus.a[WIDTH-1];
               b_msb_d  = bus.b[WIDTH-1];
`endif
            end
         end
         SHIFT: begin
            // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB result.
            diff_d   = {fs_d, diff_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            borrow_d = fs_bo;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               bout_d  = fs_bo;
               state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
               // fs_d becomes the result MSB on this same edge.
               ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; synchronous reset discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   // Handshake and status outputs decode straight from the state register.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

   // A presented result must not move until it is taken.
   a_result_stable: assert property (
      @(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=>
         (bus.out_valid && $stable(bus.diff) && $stable(bus.bout))
   );

   // Operands and results never share a cycle.
   a_no_overlap: assert property (
      @(posedge clk) disable iff (rst)
      !(bus.in_ready && bus.out_valid)
   );

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4.
// Table vectors plus hand-written backpressure, reset-abort and back-to-back runs.
// Results are compared by a scoreboard queue filled at operand accept.
module tb_serial_subtractor;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .busy (busy),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_mis = 0;
   exp_t sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      logic [W:0] t;
      exp_t       e;
      t      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      e.diff = t[W-1:0];
      e.bout = t[W];
      e.ovf  = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
      return e;
   endfunction

   // Result monitor: every taken result must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_diff", 32'(bus.diff), 32'(e.diff));
            chk("sb_bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            chk("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // One operation: offer operands, measure latency, optionally stall the result.
   task automatic op(input vec_t v, input int hold);
      exp_t e;
      int   waited;
      int   lat;
      e.diff = v.diff;
      e.bout = v.bout;
      e.ovf  = v.ovf;
      bus.a        = v.a;
      bus.b        = v.b;
      bus.bin      = v.bin;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb_q.push_back(e);
            break;
         end
         waited++;
         if (waited > 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(W));
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hold_diff",  32'(bus.diff), 32'(v.diff));
         chk("hold_bout",  32'(bus.bout), 32'(v.bout));
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         // A stray operand offer while the result is pending must be ignored.
         bus.in_valid = (i == 0);
         bus.a        = 4'd1;
         bus.b        = 4'd1;
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready",  32'(bus.in_ready), 32'd1);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
   endtask

   vec_t tbl[10];

   initial begin
      tbl[0] = '{a: 4'd9,  b: 4'd5,  bin: 1'b0, diff: 4'd4,  bout: 1'b0, ovf: 1'b1};
      tbl[1] = '{a: 4'd3,  b: 4'd5,  bin: 1'b0, diff: 4'd14, bout: 1'b1, ovf: 1'b0};
      tbl[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'd15, bout: 1'b1, ovf: 1'b0};
      tbl[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, diff: 4'd0,  bout: 1'b0, ovf: 1'b0};
      tbl[4] = '{a: 4'd8,  b: 4'd1,  bin: 1'b0, diff: 4'd7,  bout: 1'b0, ovf: 1'b1};
      tbl[5] = '{a: 4'd5,  b: 4'd2,  bin: 1'b0, diff: 4'd3,  bout: 1'b0, ovf: 1'b0};
      tbl[6] = '{a: 4'd2,  b: 4'd14, bin: 1'b0, diff: 4'd4,  bout: 1'b1, ovf: 1'b0};
      tbl[7] = '{a: 4'd7,  b: 4'd8,  bin: 1'b0, diff: 4'd15, bout: 1'b1, ovf: 1'b1};
      tbl[8] = '{a: 4'd6,  b: 4'd3,  bin: 1'b1, diff: 4'd2,  bout: 1'b0, ovf: 1'b0};
      tbl[9] = '{a: 4'd12, b: 4'd7,  bin: 1'b0, diff: 4'd5,  bout: 1'b0, ovf: 1'b1};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a   = '0;
      bus.b   = '0;
      bus.bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_diff",      32'(bus.diff), 32'd0);
      chk("rst_bout",      32'(bus.bout), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Straight-through vectors, result taken immediately.
      for (int i = 0; i < 9; i++) begin
         op(tbl[i], 0);
      end

      // Backpressure: result stalled three cycles in DONE.
      op(tbl[9], 3);

      // Reset two edges after accept: the partial result must vanish.
      bus.a = 4'd10; bus.b = 4'd3; bus.bin = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("abort_busy_before", 32'(busy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_in_ready",  32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy",      32'(busy), 32'd0);
      chk("abort_diff",      32'(bus.diff), 32'd0);
      chk("abort_bout",      32'(bus.bout), 32'd0);
      rst = 1'b0;
      begin
         logic seen;
         seen = 1'b0;
         repeat (2 * W) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
         end
         chk("abort_no_result", 32'(seen), 32'd0);
      end

      // Back-to-back random operations with in_valid held and random out_ready.
      begin
         logic drv_done;
         drv_done = 1'b0;
         fork
            begin
               int   acc;
               int   cyc;
               acc = 0;
               cyc = 0;
               bus.a   = W'($urandom_range(0, 15));
               bus.b   = W'($urandom_range(0, 15));
               bus.bin = 1'($urandom_range(0, 1));
               bus.in_valid = 1'b1;
               while (acc < 20 && cyc < 2000) begin
                  @(negedge clk);
                  cyc++;
                  if (bus.in_ready) begin
                     sb_q.push_back(model(bus.a, bus.b, bus.bin));
                     acc++;
                     @(posedge clk); #1;
                     bus.a   = W'($urandom_range(0, 15));
                     bus.b   = W'($urandom_range(0, 15));
                     bus.bin = 1'($urandom_range(0, 1));
                     if (acc >= 20) bus.in_valid = 1'b0;
                  end
               end
               bus.in_valid = 1'b0;
               chk("b2b_accepted", 32'(acc), 32'd20);
               drv_done = 1'b1;
            end
            begin
               int cyc;
               cyc = 0;
               while ((!drv_done || sb_q.size() > 0) && cyc < 4000) begin
                  @(posedge clk); #1;
                  bus.out_ready = 1'($urandom_range(0, 1));
                  cyc++;
               end
               bus.out_ready = 1'b1;
            end
         join
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      chk("end_idle", 32'(bus.in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
